// File: rtl/gol_pkg.sv
// gol_pkg: shared types and constants for the Game-of-Life generation sequencer
package gol_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, COMPUTE, COPY, DONE} gen_state_t;
  localparam int GEN_CNT_W = 16;
  function automatic int rows_of(input int regbits);
    return 1 << regbits;
  endfunction
endpackage

// File: rtl/gen_timer.sv
// gen_timer: generation-period tick counter with clear, saturation and expiry compare
module gen_timer #(
  parameter int TICKBITS = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic [TICKBITS-1:0] period,
  output logic                expired
);
  logic [TICKBITS-1:0] tick;
  logic [TICKBITS-1:0] limit;
  assign limit = (period == '0) ? '0 : period - 1'b1;
  assign expired = tick >= limit;
  // count cycles since the last generation start, holding at all-ones
  always_ff @(posedge clk or posedge reset)
    if (reset) tick <= '0;
    else if (clear) tick <= '0;
    else if (en && !(&tick)) tick <= tick + 1'b1;
endmodule

// File: rtl/gen_sequencer.sv
// gen_sequencer: per-generation row walk, next-to-previous copy and generation pacing
module gen_sequencer
  import gol_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int REGBITS  = 3,
  parameter int TICKBITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic [TICKBITS-1:0]  period,
  output logic [REGBITS-1:0]   ra1,
  output logic [REGBITS-1:0]   ra2,
  output logic [REGBITS-1:0]   ra3,
  output logic                 we_next,
  output logic [REGBITS-1:0]   wa,
  output logic                 copy_we,
  output logic [REGBITS-1:0]   ca,
  output logic                 busy,
  output logic                 gen_done,
  output logic [GEN_CNT_W-1:0] gen_count
);
  localparam int ROWS = rows_of(REGBITS);
  localparam logic [REGBITS-1:0] LAST = REGBITS'(ROWS - 1);
  if (WIDTH < 1) begin : g_width_must_be_positive
  end
  gen_state_t         state;
  logic [REGBITS-1:0] row_idx;
  logic               expired;
  logic               start;
  assign start = (state == IDLE) ? (run | step)
               : ((state == WAIT || state == DONE) && run && expired);
  assign ra2 = row_idx;
  assign ra1 = row_idx - 1'b1;
  assign ra3 = row_idx + 1'b1;
  assign wa  = row_idx;
  assign ca  = row_idx;
  gen_timer #(.TICKBITS(TICKBITS)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .en      (state != IDLE),
    .period  (period),
    .expired (expired)
  );
  // sequence compute, copy and done phases with registered strobes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      row_idx   <= '0;
      we_next   <= 1'b0;
      copy_we   <= 1'b0;
      busy      <= 1'b0;
      gen_done  <= 1'b0;
      gen_count <= '0;
    end else if (start) begin
      state    <= COMPUTE;
      row_idx  <= '0;
      we_next  <= 1'b1;
      copy_we  <= 1'b0;
      busy     <= 1'b1;
      gen_done <= 1'b0;
    end else
      case (state)
        COMPUTE: begin
          row_idx <= row_idx + 1'b1;
          if (row_idx == LAST) begin
            state   <= COPY;
            we_next <= 1'b0;
            copy_we <= 1'b1;
          end
        end
        COPY: begin
          row_idx <= row_idx + 1'b1;
          if (row_idx == LAST) begin
            state     <= DONE;
            copy_we   <= 1'b0;
            gen_done  <= 1'b1;
            gen_count <= gen_count + 1'b1;
          end
        end
        DONE: begin
          gen_done <= 1'b0;
          busy     <= 1'b0;
          state    <= run ? WAIT : IDLE;
        end
        WAIT: if (!run) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_gen_sequencer.sv
// tb_gen_sequencer: table, directed and model-checked random tests of gen_sequencer
module tb_gen_sequencer;
  localparam int RB = 3;
  localparam int TB = 24;
  localparam int R  = 8;
  logic clk = 0, reset = 0, run = 0, step = 0;
  logic [TB-1:0] period = '0;
  logic [RB-1:0] ra1, ra2, ra3, wa, ca;
  logic we_next, copy_we, busy, gen_done;
  logic [15:0] gen_count;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int period; int interval;} vec_t;
  vec_t tbl[6];
  int plist[8];
  bit m_act, m_wait;
  int m_pos, m_since, m_gc;

  gen_sequencer #(.WIDTH(8), .REGBITS(RB), .TICKBITS(TB)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .period(period),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .we_next(we_next), .wa(wa),
    .copy_we(copy_we), .ca(ca), .busy(busy), .gen_done(gen_done),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rst_vec();
    return {28'b0, busy, we_next, copy_we, gen_done, gen_count, wa, ca, ra1, ra2, ra3};
  endfunction

  localparam logic [63:0] RST_EXP = {28'b0, 4'b0, 16'h0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd1};

  task automatic m_reset();
    m_act = 0; m_wait = 0; m_pos = 0; m_since = 0; m_gc = 0;
  endtask

  task automatic m_step(input bit r, input bit s, input int p);
    bit st, done_now;
    int thr;
    thr = (p == 0) ? 0 : p - 1;
    done_now = m_act && m_pos == 2 * R;
    if (!m_act && !m_wait) st = r | s;
    else if (m_wait || done_now) st = r && (m_since >= thr);
    else st = 0;
    if (st) begin
      m_act = 1; m_wait = 0; m_pos = 0; m_since = 0;
    end else if (m_wait || done_now) begin
      m_act = 0; m_wait = r; m_since++;
    end else if (m_act) begin
      m_pos++; m_since++;
      if (m_pos == 2 * R) m_gc = (m_gc + 1) % 65536;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    run = 0; step = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    m_reset();
  endtask

  task automatic wait_gd(output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gen_done && n < 200);
    chk("gen_done_timeout", {63'b0, gen_done}, 64'd1);
    at = gen_done ? cyc : -1;
  endtask

  initial begin
    int t0, t1, cnt, bcnt, gc0;
    tbl = '{'{40, 40}, '{5, 17}, '{0, 17}, '{17, 17}, '{18, 18}, '{1, 17}};
    plist = '{0, 1, 5, 16, 17, 18, 25, 40};
    #1 reset = 1;
    #1 chk("reset_values", rst_vec(), RST_EXP);
    @(negedge clk) reset = 0;
    m_reset();

    // single step generation walk
    @(negedge clk) step = 1;
    for (int i = 0; i < 2 * R + 1; i++) begin
      @(negedge clk);
      step = 0;
      chk($sformatf("step_busy_%0d", i), {63'b0, busy}, 64'd1);
      if (i < R) begin
        chk($sformatf("step_compute_%0d", i), {51'b0, we_next, copy_we, wa, ra1, ra2, ra3},
            {51'b0, 1'b1, 1'b0, 3'(i), 3'((i + R - 1) % R), 3'(i), 3'((i + 1) % R)});
      end else if (i < 2 * R) begin
        chk($sformatf("step_copy_%0d", i), {59'b0, we_next, copy_we, ca},
            {59'b0, 1'b0, 1'b1, 3'(i - R)});
      end else begin
        chk("step_done", {44'b0, we_next, copy_we, gen_done, 1'b0, gen_count},
            {44'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1});
      end
    end
    @(negedge clk);
    chk("step_end", {46'b0, busy, gen_done, gen_count}, {46'b0, 1'b0, 1'b0, 16'd1});
    repeat (5) @(negedge clk);
    chk("step_no_repeat", {47'b0, busy, gen_count}, {47'b0, 1'b0, 16'd1});

    // free-running pacing across a table of periods
    foreach (tbl[k]) begin
      do_reset();
      period = TB'(tbl[k].period);
      run = 1;
      wait_gd(t0);
      chk($sformatf("p%0d_count_1", tbl[k].period), {48'b0, gen_count}, 64'd1);
      for (int g = 2; g <= 5; g++) begin
        wait_gd(t1);
        chk($sformatf("p%0d_interval_%0d", tbl[k].period, g), 64'(t1 - t0), 64'(tbl[k].interval));
        chk($sformatf("p%0d_count_%0d", tbl[k].period, g), {48'b0, gen_count}, 64'(g));
        t0 = t1;
      end
      run = 0;
    end

    // run dropped mid-compute, step while busy ignored
    do_reset();
    period = TB'(40);
    run = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    run = 0;
    step = 1;
    gc0 = gen_count;
    cnt = 0; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      step = 0;
      cnt += gen_done;
      bcnt += busy;
    end
    chk("drop_gen_done_once", 64'(cnt), 64'd1);
    chk("drop_busy_cycles", 64'(bcnt), 64'd14);
    chk("drop_count", {48'b0, gen_count}, 64'(gc0 + 1));

    // asynchronous reset during copy
    do_reset();
    @(negedge clk) step = 1;
    @(negedge clk) step = 0;
    repeat (9) @(negedge clk);
    chk("pre_reset_in_copy", {63'b0, copy_we}, 64'd1);
    #2 reset = 1;
    #1 chk("reset_mid_copy", rst_vec(), RST_EXP);
    @(negedge clk) reset = 0;
    repeat (3) @(negedge clk);
    chk("after_reset_idle", rst_vec(), RST_EXP);
    m_reset();

    // generation counter wrap
    force dut.gen_count = 16'hFFFF;
    @(negedge clk);
    release dut.gen_count;
    chk("wrap_preload", {48'b0, gen_count}, 64'hFFFF);
    step = 1;
    @(negedge clk) step = 0;
    wait_gd(t0);
    chk("wrap_count", {48'b0, gen_count}, 64'd0);
    @(negedge clk);
    chk("wrap_pulse_width", {63'b0, gen_done}, 64'd0);

    // randomized stimulus against the reference model
    do_reset();
    period = TB'(17);
    for (int i = 0; i < 3000; i++) begin
      bit e_we, e_cp, e_gd;
      @(posedge clk);
      m_step(run, step, int'(period));
      @(negedge clk);
      e_we = m_act && m_pos < R;
      e_cp = m_act && m_pos >= R && m_pos < 2 * R;
      e_gd = m_act && m_pos == 2 * R;
      chk($sformatf("rand_%0d", i),
          {29'b0, busy, we_next, copy_we, gen_done, gen_count,
           e_we ? {wa, ra1, ra2, ra3} : 12'b0, e_cp ? ca : 3'b0},
          {29'b0, m_act, e_we, e_cp, e_gd, 16'(m_gc),
           e_we ? {3'(m_pos), 3'(m_pos + R - 1), 3'(m_pos), 3'(m_pos + 1)} : 12'b0,
           e_cp ? 3'(m_pos - R) : 3'b0});
      if ($urandom_range(0, 39) == 0) run = ~run;
      step = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) period = TB'(plist[$urandom_range(0, 7)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gen_sequencer.md
# gen_sequencer

Generation sequencer for the Game-of-Life core. It replaces the free-running row controller and the ad-hoc slow divider with one clocked FSM. Each generation, it walks every row through the three-port previous-state register file and the neighbourhood decoder, then writes the results into the next-state register file. It then copies next-state back into previous-state and paces generations with a programmable interval timer.

## Interface
Parameters:
- WIDTH, 8, row width in cells (passed through for package consistency; no datapath here)
- REGBITS, 3, row address bits; ROWS = 2**REGBITS
- TICKBITS, 24, width of generation-period counter

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  async active-high reset
- run  in  1  level; free-running generations while high
- step  in  1  single-cycle pulse; one generation when idle and run low
- period  in  TICKBITS  clk cycles between generation starts; 0 treated as 1
- ra1  out  REGBITS  read address, row above (row-1 mod ROWS)
- ra2  out  REGBITS  read address, current row
- ra3  out  REGBITS  read address, row below (row+1 mod ROWS)
- we_next  out  1  write enable, next-state file
- wa  out  REGBITS  next-state write address
- copy_we  out  1  write enable, previous-state file (copy from next-state)
- ca  out  REGBITS  copy address (read next-state, write previous-state)
- busy  out  1  high in COMPUTE, COPY, DONE
- gen_done  out  1  one-cycle pulse at end of each generation
- gen_count  out  16  completed-generation counter

## Operation
- States: IDLE, WAIT, COMPUTE, COPY, DONE. Registered row index row_idx, tick counter tick.
- IDLE: run=1 -> COMPUTE; else step=1 -> COMPUTE; else stay.
- COMPUTE: ROWS cycles, row_idx 0..ROWS-1; we_next=1, wa=row_idx; ra2=row_idx, ra1/ra3 wrap (row 0: ra1=ROWS-1; row ROWS-1: ra3=0). Read files are combinational, so each row is written on the same edge. Last row -> COPY, row_idx reset to 0.
- COPY: ROWS cycles; copy_we=1, ca=row_idx 0..ROWS-1; last -> DONE.
- DONE: one cycle; gen_done=1, gen_count+1 (wraps 0xFFFF->0). Next: run=0 -> IDLE; run=1 and tick >= period-1 -> COMPUTE; else WAIT.
- WAIT: run=0 -> IDLE; tick >= period-1 -> COMPUTE.
- tick: cleared on every entry to COMPUTE, increments every cycle outside IDLE, saturates at all-ones.
- step while busy or WAIT: ignored, not queued. step and run both high in IDLE: one start, identical to run alone.
- run dropped during COMPUTE/COPY: generation completes (no torn state), then IDLE via DONE.
- period changed mid-generation: new value used at the next tick compare.

## Timing
- Reset values (async, immediate): state IDLE, row_idx 0, tick 0, we_next 0, copy_we 0, busy 0, gen_done 0, gen_count 0, wa 0, ca 0, ra2 0, ra1 ROWS-1, ra3 1.
- Start latency: run/step sampled in IDLE -> COMPUTE on the next edge; first we_next high in that cycle.
- Generation length: busy high for exactly 2*ROWS+1 cycles (17 for ROWS=8).
- Steady-state run: gen_done period = max(period, 2*ROWS+1) cycles.
- we_next and copy_we are never high in the same cycle.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

## Structure
- Shared package gol_pkg: state enum gen_state_t {IDLE, WAIT, COMPUTE, COPY, DONE}, ROWS localparam derivation, GEN_CNT_W=16.
- One sub-module: gen_timer, the tick counter with clear, saturate and the period compare (treats 0 as 1), exposing a single expired flag.
- Wrap arithmetic is REGBITS-wide natural overflow; no modulo operators.

## Test plan
- Reset asserted mid-COPY (ROWS=8) -> all outputs return to reset values the same cycle, no clock needed; after release, state IDLE.
- run=0, single step pulse -> busy 17 cycles; wa 0..7 with ra1 7,0..6 and ra3 1..7,0; copy_we 8 cycles ca 0..7; gen_done one pulse; gen_count=1.
- run=1, period=40 -> gen_done every 40 cycles across 5 generations; gen_count 1..5.
- run=1, period=5 and period=0 -> gen_done every 17 cycles, never in WAIT.
- run dropped on 3rd COMPUTE cycle -> remaining rows and full COPY complete, gen_done once, then IDLE; step during busy produces no extra generation.
- gen_count preloaded by forcing to 0xFFFF, one step -> gen_count=0x0000, gen_done pulses.
